// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key-schedule block.
// Contents: round/Rcon constants, FSM state type, S-box table, and the
// byte helpers xtime / inv_xtime / sbox / rot_word.
package aes_pkg;

  localparam int unsigned AES128_NR = 10;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROUND_W   = 4;
  localparam logic [7:0]  RCON_LAST = 8'h36;
  localparam logic [7:0]  RCON_FIRST = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XOR  = 2'd1,
    ST_SUB  = 2'd2
`ifdef AES_INV_KEY_FWD_EN
    ,
    ST_FWD  = 2'd3
`endif
  } state_t;

  // Forward S-box; entry 0 is the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // GF(2^8) multiply by x.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
  endfunction

  // GF(2^8) divide by x; walks Rcon backward (36 -> 1B -> 80 -> ... -> 01).
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1B) >> 1) | 8'h80) : (x >> 1);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // RotWord(a,b,c,d) = (b,c,d,a), byte a in the MSBs.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
// Ports: word (in, 32) - input word; sub_word (out, 32) - substituted word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  assign sub_word = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_inv_key_expand.sv
// Inverse AES-128 key schedule: loaded with the round-10 key, each step
// walks back one round (XOR phase then SubWord phase) and presents the
// previous round key on key_o.
// Ports: clk_i, rst_i (async, active-high), load_i/key_i (load a key),
// step_i (request previous round key), ready_o (idle), valid_o (key valid),
// key_o (128-bit round key, word0 in [127:96]), round_o (round index).
// Optional macro AES_INV_KEY_FWD_EN: key_i is the cipher key and the block
// runs the forward expansion to round 10 before becoming ready.
module aes_inv_key_expand
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [127:0] key_i,
  input  logic         step_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [127:0] key_o,
  output logic [3:0]   round_o
);

  state_t      state;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sbox_in;
  logic [31:0] sub_w;

`ifdef AES_INV_KEY_FWD_EN
  logic        fwd_phase;
`endif

  assign w0 = key_o[127:96];
  assign w1 = key_o[95:64];
  assign w2 = key_o[63:32];
  assign w3 = key_o[31:0];

  // Both the backward SUB phase and the forward phase feed the S-box from w3.
  assign sbox_in = rot_word(w3);

  aes_sbox_word u_sbox (
    .word     (sbox_in),
    .sub_word (sub_w)
  );

  // Control FSM and key register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      key_o     <= '0;
      round_o   <= '0;
      rcon      <= RCON_LAST;
`ifdef AES_INV_KEY_FWD_EN
      fwd_phase <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_i) begin
            key_o     <= key_i;
`ifdef AES_INV_KEY_FWD_EN
            round_o   <= '0;
            rcon      <= RCON_FIRST;
            fwd_phase <= 1'b0;
            valid_o   <= 1'b0;
            ready_o   <= 1'b0;
            state     <= ST_FWD;
`else
            round_o   <= ROUND_W'(AES128_NR);
            rcon      <= RCON_LAST;
            valid_o   <= 1'b1;
`endif
          end else if (step_i && valid_o && (round_o != '0)) begin
            ready_o <= 1'b0;
            valid_o <= 1'b0;
            state   <= ST_XOR;
          end
        end

        // Undo the forward chaining of w1..w3; w0 is held for the SUB phase.
        ST_XOR: begin
          key_o[95:0] <= {w1 ^ w0, w2 ^ w1, w3 ^ w2};
          state       <= ST_SUB;
        end

        // Recover w0 using the already-restored w3.
        ST_SUB: begin
          key_o[127:96] <= w0 ^ sub_w ^ {rcon, 24'h0};
          round_o       <= round_o - 4'd1;
          rcon          <= inv_xtime(rcon);
          ready_o       <= 1'b1;
          valid_o       <= 1'b1;
          state         <= ST_IDLE;
        end

`ifdef AES_INV_KEY_FWD_EN
        // Phase 0 computes w0n; phase 1 chains it into w1n..w3n.
        ST_FWD: begin
          if (!fwd_phase) begin
            key_o[127:96] <= w0 ^ sub_w ^ {rcon, 24'h0};
            fwd_phase     <= 1'b1;
          end else begin
            key_o[95:0] <= {w1 ^ w0, w2 ^ w1 ^ w0, w3 ^ w2 ^ w1 ^ w0};
            rcon        <= xtime(rcon);
            fwd_phase   <= 1'b0;
            if (round_o == ROUND_W'(AES128_NR - 1)) begin
              round_o <= ROUND_W'(AES128_NR);
              rcon    <= RCON_LAST;
              ready_o <= 1'b1;
              valid_o <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              round_o <= round_o + 4'd1;
            end
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
